// File: rtl/musa_run_ctrl.sv
// musa_run_ctrl: bring-up sequencer for the MUSA pipelined datapath.
// Loads a program into imem, runs the core until a halt PC or a cycle
// budget, then streams a window of dmem out through a valid/ready port.
// Optional build macro: MUSA_RUN_CTRL_CSUM_EN enables the load checksum.
module musa_run_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 9,
    parameter int CYC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  prog_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic [ADDR_W-1:0] core_pc,
    input  logic [ADDR_W-1:0] halt_pc,
    input  logic [CYC_W-1:0]  run_budget,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [LEN_W-1:0]  dump_len,
    output logic [ADDR_W-1:0] dmem_raddr,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    input  logic              dump_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycles,
    output logic [DATA_W-1:0] load_csum
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_prog_len;
    logic [ADDR_W-1:0]   r_halt_pc;
    logic [CYC_W-1:0]    r_budget;
    logic [ADDR_W-1:0]   r_dump_base;
    logic [LEN_W-1:0]    r_dump_len;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    r_k;
    logic [CYC_W-1:0]    r_cycles;
    logic                r_timeout;
    logic [DATA_W-1:0]   r_hold;

    logic                w_start_ok;
    logic                w_ld_fire;
    logic                w_ld_last;
    logic [CYC_W:0]      w_cyc_inc;
    logic                w_halt;
    logic                w_budget_hit;
    logic                w_run_exit;
    logic                w_dump_fire;
    logic                w_dump_last;
    logic [ADDR_W-1:0]   w_koff;

    // Cycle counter stops at all-ones instead of wrapping.
    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    assign w_start_ok   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_ld_fire    = (r_state == S_LOAD) && ld_valid;
    assign w_ld_last    = w_ld_fire && (r_idx == r_prog_len - LEN_W'(1));
    assign w_cyc_inc    = {1'b0, r_cycles} + (CYC_W+1)'(1);
    assign w_halt       = (r_state == S_RUN) && (core_pc == r_halt_pc);
    // Halt takes priority when both conditions hit in the same cycle.
    assign w_budget_hit = (r_state == S_RUN) && !w_halt && (r_budget != '0) &&
                          (w_cyc_inc == {1'b0, r_budget});
    assign w_run_exit   = w_halt || w_budget_hit;
    assign w_dump_fire  = (r_state == S_DUMP_OUT) && dump_ready;
    assign w_dump_last  = w_dump_fire && (r_k == r_dump_len - LEN_W'(1));

    // Word index to byte offset; sums wrap modulo 2^ADDR_W.
    assign w_koff     = {{(ADDR_W-LEN_W-2){1'b0}}, r_k, 2'b00};
    assign imem_addr  = {{(ADDR_W-LEN_W-2){1'b0}}, r_idx, 2'b00};
    assign imem_wdata = ld_data;
    assign dmem_raddr = r_dump_base + w_koff;
    assign dump_addr  = r_dump_base + w_koff;
    assign dump_data  = r_hold;
    assign timeout    = r_timeout;
    assign cycles     = r_cycles;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        w_next     = r_state;
        ld_ready   = 1'b0;
        imem_we    = 1'b0;
        core_rst_n = 1'b1;
        core_en    = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                core_rst_n = 1'b0;
                busy       = 1'b0;
                if (w_start_ok) w_next = (prog_len != '0) ? S_LOAD : S_RUN;
            end
            S_LOAD: begin
                core_rst_n = 1'b0;
                ld_ready   = 1'b1;
                imem_we    = ld_valid;
                if (w_ld_last) w_next = S_RUN;
            end
            S_RUN: begin
                core_en = 1'b1;
                if (w_run_exit) w_next = (r_dump_len != '0) ? S_DUMP_RD : S_DONE;
            end
            S_DUMP_RD:   w_next = S_DUMP_WAIT;
            S_DUMP_WAIT: w_next = S_DUMP_OUT;
            S_DUMP_OUT: begin
                dump_valid = 1'b1;
                if (w_dump_fire) w_next = w_dump_last ? S_DONE : S_DUMP_RD;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (w_start_ok) w_next = (prog_len != '0) ? S_LOAD : S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Session parameters, load/dump indices, cycle count and dump hold word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prog_len  <= '0;
            r_halt_pc   <= '0;
            r_budget    <= '0;
            r_dump_base <= '0;
            r_dump_len  <= '0;
            r_idx       <= '0;
            r_k         <= '0;
            r_cycles    <= '0;
            r_timeout   <= 1'b0;
            r_hold      <= '0;
        end else begin
            if (w_start_ok) begin
                r_prog_len  <= prog_len;
                r_halt_pc   <= halt_pc;
                r_budget    <= run_budget;
                r_dump_base <= dump_base;
                r_dump_len  <= dump_len;
                r_idx       <= '0;
                r_k         <= '0;
                r_cycles    <= '0;
                r_timeout   <= 1'b0;
            end
            if (w_ld_fire) r_idx <= r_idx + LEN_W'(1);
            if (r_state == S_RUN) r_cycles <= sat_inc(r_cycles);
            if (w_run_exit) r_timeout <= w_budget_hit;
            if (r_state == S_DUMP_WAIT) r_hold <= dmem_rdata;
            if (w_dump_fire) r_k <= r_k + LEN_W'(1);
        end
    end

`ifdef MUSA_RUN_CTRL_CSUM_EN
    logic [DATA_W-1:0] r_csum;

    // Wrapping sum of every program word accepted in LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_csum <= '0;
        else if (w_start_ok) r_csum <= '0;
        else if (w_ld_fire)  r_csum <= r_csum + ld_data;
    end

    assign load_csum = r_csum;
`else
    assign load_csum = '0;
`endif

endmodule

// File: tb/tb_musa_run_ctrl.sv
// Directed bench for musa_run_ctrl with a core PC stub and a dmem model.
module tb_musa_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  prog_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        core_en;
    logic [31:0] core_pc;
    logic [31:0] halt_pc;
    logic [15:0] run_budget;
    logic [31:0] dump_base;
    logic [8:0]  dump_len;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dump_valid;
    logic [31:0] dump_addr;
    logic [31:0] dump_data;
    logic        dump_ready;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;
    logic [31:0] load_csum;

    musa_run_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_en(core_en), .core_pc(core_pc),
        .halt_pc(halt_pc), .run_budget(run_budget), .dump_base(dump_base),
        .dump_len(dump_len), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_ready(dump_ready), .busy(busy), .done(done), .timeout(timeout),
        .cycles(cycles), .load_csum(load_csum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: PC steps by 4 while enabled, or sits at 0 when pc_stuck.
    logic [31:0] r_pc;
    bit          pc_stuck;
    always @(posedge clk) begin
        if (!core_rst_n)   r_pc <= 32'h0;
        else if (core_en)  r_pc <= r_pc + 32'd4;
    end
    assign core_pc = pc_stuck ? 32'h0 : r_pc;

    // Synchronous-read dmem whose content is address ^ 0xA5A5A5A5.
    always @(posedge clk) dmem_rdata <= dmem_raddr ^ 32'hA5A5A5A5;

    int          n_chk;
    int          n_err;
    logic [31:0] prog [0:7];
    int          ld_n;
    int          ld_i;
    bit          ld_en;
    bit          dr_toggle;
    bit          start_pend;
    logic [31:0] wa [0:15];
    logic [31:0] wd [0:15];
    logic [31:0] da [0:15];
    logic [31:0] dd [0:15];
    int          nw;
    int          nd;
    int          en_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, then log what the DUT shows.
    task automatic cyc();
        @(negedge clk);
        start      = start_pend;
        start_pend = 1'b0;
        ld_valid   = ld_en && (ld_i < ld_n);
        ld_data    = ld_valid ? prog[ld_i] : 32'h0;
        dump_ready = dr_toggle ? ~dump_ready : 1'b1;
        #1;
        if (imem_we) begin
            if (nw < 16) begin
                wa[nw] = imem_addr;
                wd[nw] = imem_wdata;
            end
            nw++;
        end
        if (ld_valid && ld_ready) ld_i++;
        if (core_en) en_cnt++;
        if (dump_valid && dump_ready) begin
            if (nd < 16) begin
                da[nd] = dump_addr;
                dd[nd] = dump_data;
            end
            nd++;
        end
    endtask

    task automatic begin_session(input int np, input logic [31:0] hpc,
                                 input logic [15:0] bud, input logic [31:0] base,
                                 input int dl);
        prog_len   = 9'(np);
        halt_pc    = hpc;
        run_budget = bud;
        dump_base  = base;
        dump_len   = 9'(dl);
        nw = 0; nd = 0; en_cnt = 0;
        ld_i = 0; ld_n = np; ld_en = 1'b1;
        start_pend = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!done && n < 400);
        chk(tag, {31'h0, done}, 32'h1);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ld_ready"},   {31'h0, ld_ready},   32'h0);
        chk({p, "_imem_we"},    {31'h0, imem_we},    32'h0);
        chk({p, "_imem_addr"},  imem_addr,           32'h0);
        chk({p, "_core_rst_n"}, {31'h0, core_rst_n}, 32'h0);
        chk({p, "_core_en"},    {31'h0, core_en},    32'h0);
        chk({p, "_dmem_raddr"}, dmem_raddr,          32'h0);
        chk({p, "_dump_valid"}, {31'h0, dump_valid}, 32'h0);
        chk({p, "_dump_addr"},  dump_addr,           32'h0);
        chk({p, "_dump_data"},  dump_data,           32'h0);
        chk({p, "_busy"},       {31'h0, busy},       32'h0);
        chk({p, "_done"},       {31'h0, done},       32'h0);
        chk({p, "_timeout"},    {31'h0, timeout},    32'h0);
        chk({p, "_cycles"},     {16'h0, cycles},     32'h0);
        chk({p, "_load_csum"},  load_csum,           32'h0);
    endtask

    initial begin
        logic [31:0] exp_csum;
        int n;
        n_chk = 0; n_err = 0;
        rst = 1'b0; start = 1'b0; prog_len = '0; ld_valid = 1'b0; ld_data = '0;
        halt_pc = '0; run_budget = '0; dump_base = '0; dump_len = '0;
        dump_ready = 1'b0; pc_stuck = 1'b0; dr_toggle = 1'b0; start_pend = 1'b0;
        ld_en = 1'b0; ld_n = 0; ld_i = 0; nw = 0; nd = 0; en_cnt = 0;
        for (int i = 0; i < 8; i++) prog[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_zero("rst");
        @(negedge clk);
        rst = 1'b1;

        // Load 3 words, PC counts 0,4,8, halt at 8
        prog[0] = 32'h3C011001; prog[1] = 32'h34210004; prog[2] = 32'h00000000;
        pc_stuck = 1'b0;
        begin_session(3, 32'h8, 16'd0, 32'h0, 0);
        wait_done("t1_done");
        chk("t1_nw", nw, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_waddr", wa[i], 32'(4 * i));
            chk("t1_wdata", wd[i], prog[i]);
        end
        chk("t1_en_cnt",  en_cnt, 3);
        chk("t1_cycles",  {16'h0, cycles}, 32'd3);
        chk("t1_timeout", {31'h0, timeout}, 32'h0);
        chk("t1_busy",    {31'h0, busy}, 32'h0);
        chk("t1_rst_n",   {31'h0, core_rst_n}, 32'h1);
        chk("t1_core_en", {31'h0, core_en}, 32'h0);
        chk("t1_nd",      nd, 0);

        // PC stuck at 0, budget 10
        pc_stuck = 1'b1;
        begin_session(0, 32'h100, 16'd10, 32'h0, 0);
        wait_done("t2_done");
        chk("t2_en_cnt",  en_cnt, 10);
        chk("t2_timeout", {31'h0, timeout}, 32'h1);
        chk("t2_cycles",  {16'h0, cycles}, 32'd10);
        chk("t2_nw",      nw, 0);

        // Halt and budget in the same cycle: halt wins
        begin_session(0, 32'h0, 16'd1, 32'h0, 0);
        wait_done("t2b_done");
        chk("t2b_timeout", {31'h0, timeout}, 32'h0);
        chk("t2b_cycles",  {16'h0, cycles}, 32'd1);

        // Dump 4 words with dump_ready toggling
        dr_toggle = 1'b1;
        begin_session(0, 32'h0, 16'd0, 32'h10010000, 4);
        wait_done("t3_done");
        dr_toggle = 1'b0;
        chk("t3_nd", nd, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_daddr", da[i], 32'h10010000 + 32'(4 * i));
            chk("t3_ddata", dd[i], (32'h10010000 + 32'(4 * i)) ^ 32'hA5A5A5A5);
        end
        chk("t3_nw", nw, 0);
        chk("t3_timeout", {31'h0, timeout}, 32'h0);

        // Zero program and zero dump: straight through RUN to DONE
        begin_session(0, 32'h0, 16'd0, 32'h0, 0);
        wait_done("t4_done");
        chk("t4_nw", nw, 0);
        chk("t4_nd", nd, 0);
        chk("t4_en_cnt", en_cnt, 1);

        // Reset mid-LOAD after 2 of 5 words
        pc_stuck = 1'b0;
        for (int i = 0; i < 5; i++) prog[i] = 32'h1000 + 32'(i);
        begin_session(5, 32'h0, 16'd0, 32'h0, 0);
        n = 0;
        while (ld_i < 2 && n < 50) begin
            cyc();
            n++;
        end
        chk("t5_two_words", ld_i, 2);
        @(posedge clk);
        #1;
        chk("t5_nw_before", nw, 2);
        rst = 1'b0;
        #1;
        chk_zero("t5");
        ld_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        begin_session(5, 32'h0, 16'd0, 32'h0, 0);
        wait_done("t5_done");
        chk("t5_nw", nw, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t5_waddr", wa[i], 32'(4 * i));
            chk("t5_wdata", wd[i], prog[i]);
        end

        // Load checksum
        prog[0] = 32'hFFFFFFFF; prog[1] = 32'h00000002;
        begin_session(2, 32'h0, 16'd0, 32'h0, 0);
        wait_done("t6_done");
`ifdef MUSA_RUN_CTRL_CSUM_EN
        exp_csum = 32'h00000001;
`else
        exp_csum = 32'h00000000;
`endif
        chk("t6_csum", load_csum, exp_csum);
        chk("t6_nw", nw, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/musa_run_ctrl.md
Name: musa_run_ctrl

Overview:
- Sequencer that wraps the MUSA pipelined datapath for bring-up and regression.
- Streams a program into instruction memory, then releases the core reset and clock-enable.
- Stops the core on a halt PC or when a cycle budget runs out, then streams a window of data memory out for checking.
- Replaces manual load, run and inspect steps in benches and on the FPGA host link.

Parameters:
- DATA_W, 32, instruction/data word width.
- ADDR_W, 32, byte-address width of imem/dmem/PC.
- LEN_W, 9, width of word-count inputs (max 511 words).
- CYC_W, 16, width of cycle counter and budget.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle pulse; begins a session from IDLE or DONE.
- prog_len  in  LEN_W  program words to load; sampled at start.
- ld_valid  in  1  host program word valid.
- ld_data  in  DATA_W  host program word.
- ld_ready  out  1  controller accepts ld_data.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  byte address = word index * 4.
- imem_wdata  out  DATA_W  word written.
- core_rst_n  out  1  datapath reset, active-low.
- core_en  out  1  datapath clock-enable.
- core_pc  in  ADDR_W  datapath PC.
- halt_pc  in  ADDR_W  PC value that ends RUN; sampled at start.
- run_budget  in  CYC_W  max RUN cycles; 0 = unlimited; sampled at start.
- dump_base  in  ADDR_W  first dmem byte address to dump; sampled at start.
- dump_len  in  LEN_W  words to dump; sampled at start.
- dmem_raddr  out  ADDR_W  dmem read address.
- dmem_rdata  in  DATA_W  dmem data, valid 1 cycle after dmem_raddr.
- dump_valid  out  1  dump word valid.
- dump_addr  out  ADDR_W  byte address of dump_data.
- dump_data  out  DATA_W  dumped word.
- dump_ready  in  1  consumer accepts dump word.
- busy  out  1  state not IDLE/DONE.
- done  out  1  high in DONE.
- timeout  out  1  RUN ended by budget, not halt; valid in DONE.
- cycles  out  CYC_W  RUN cycle count, saturating.
- load_csum  out  DATA_W  see Optional Feature.

Behaviour:
- Reset (rst low, async): state IDLE, all outputs 0; core_rst_n=0; counters and address registers 0.
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE.
- IDLE/DONE + start: latch inputs, clear cycles/timeout/done. Go to LOAD if prog_len != 0, else RUN. start in any other state is ignored.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready, in the same cycle: imem_we=1, imem_wdata=ld_data, imem_addr=idx*4; idx++.
  - After word prog_len-1 is accepted, go to RUN next cycle.
  - core_rst_n=0 throughout.
- RUN:
  - core_rst_n=1, core_en=1; cycles increments each RUN cycle, saturating at all-ones.
  - If core_pc==halt_pc, leave RUN next cycle, timeout=0.
  - Otherwise, if run_budget!=0 and cycles+1==run_budget, leave RUN with timeout=1.
  - Halt and budget in the same cycle: halt wins.
  - Exit goes to DUMP_RD if dump_len!=0, else DONE.
- DUMP:
  - core_en=0, core_rst_n stays 1 so dmem holds state.
  - DUMP_RD: dmem_raddr=dump_base+4*k, then go to DUMP_WAIT.
  - DUMP_WAIT: capture dmem_rdata into hold register, then go to DUMP_OUT.
  - DUMP_OUT: dump_valid=1, dump_data/dump_addr stable until dump_ready. On accept, k++. If k was dump_len-1 go to DONE, else DUMP_RD.
  - Address arithmetic wraps modulo 2^ADDR_W.
- DONE: done=1, core_en=0, core_rst_n=1; outputs hold until next start.
- Latency: first imem write in the cycle ld_valid is seen in LOAD. RUN starts 1 cycle after the last load word. Each dump word takes ≥3 cycles.
- rst asserted mid-session: immediate return to IDLE; no partial-state outputs survive.

Optional Feature:
- Macro: MUSA_RUN_CTRL_CSUM_EN.
- Defined: load_csum = 32-bit wrapping sum of all words accepted in LOAD. Cleared at start, held through DONE.
- Undefined: load_csum tied to 0 and no adder is synthesized.

Test Plan:
- Load 3 words 0x3C011001, 0x34210004, 0x00000000 with halt_pc=0x8, budget=0 → imem writes at addrs 0x0, 0x4, 0x8. Core stub PC counts 0, 4, 8 → RUN lasts 3 cycles, cycles=3, timeout=0, done=1.
- Stub PC stuck at 0, run_budget=10 → core_en high exactly 10 cycles, timeout=1, cycles=10.
- dump_len=4, dump_base=0x10010000, dmem model returns addr^0xA5A5A5A5, dump_ready toggling every other cycle → 4 words, addrs 0x10010000–0x1001000C, correct data, none lost or duplicated.
- prog_len=0 and dump_len=0 → IDLE→RUN→DONE, no imem_we, no dump_valid.
- rst pulled low mid-LOAD after 2 of 5 words → all outputs 0 immediately. A new start reloads from addr 0.
- With MUSA_RUN_CTRL_CSUM_EN, words 0xFFFFFFFF, 0x00000002 → load_csum=0x00000001. Without the macro → load_csum=0.
